vga_scale_fetch: RTL and testbench
==================================

# vga_scale_fetch

Frame-buffer fetch and scaling stage between the display BRAM and the VGA pins. It consumes raster timing from the VGA controller, generates BRAM read addresses that map each output pixel to a source pixel by integer nearest-neighbour upscaling, and realigns the returned pixel data with delayed sync and visible strobes. Scaling is parametrised in both axes through DDA accumulators, with no fixed delta bit patterns. The colour-mapping modes are selectable at run time.

## Interface
- SRC_W, 128: source pixels per line; 1 ≤ SRC_W ≤ DST_W
- SRC_H, 96: source lines per frame; 1 ≤ SRC_H ≤ DST_H
- DST_W, 640: visible output pixels per line
- DST_H, 480: visible output lines per frame
- ADDR_W, 14: BRAM address width; SRC_W*SRC_H ≤ 2^ADDR_W
- DATA_W, 8: pixel and colour channel width
- BRAM_LATENCY, 1: BRAM read latency in cycles (1..4)
- CLK  in  1  pixel clock
- RESET_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  when low, all state and pipeline registers hold
- MODE  in  2  00 gray, 01 inverted gray, 10 green-only, 11 checker test pattern
- VGA_HS_I, VGA_VS_I, VGA_VISIBLE_I  in  1 each  raster timing from controller; VS active-high
- BRAM_ADDR  out  ADDR_W  registered read address
- BRAM_DOUT  in  DATA_W  read data
- VGA_R, VGA_G, VGA_B  out  DATA_W each  registered colour
- VGA_HS, VGA_VS, VGA_VISIBLE  out  1 each  timing inputs delayed by PIPE = BRAM_LATENCY+2

## Operation
- State: ARMED flag, col (clog2 SRC_W), row (clog2 SRC_H), row_base (ADDR_W), acc_x (clog2(DST_W)+1), acc_y (clog2(DST_H)+1), vis_d (previous VISIBLE_I).
- Reset: every register is 0, including ARMED and the delay pipelines. All outputs are 0.
- While ARMED=0: BRAM_ADDR holds 0 and VGA_R/G/B are 0. ARMED sets on the first cycle with VS_I=1 and stays set until reset.
- VS_I=1: frame restart. col, row, row_base, acc_x and acc_y are cleared, and BRAM_ADDR is set to 0.
- VISIBLE_I=1 (ARMED, VS_I=0):
  - BRAM_ADDR ← row_base + col.
  - Then s = acc_x + SRC_W. If s ≥ DST_W: acc_x ← s − DST_W and col ← col+1, saturating at SRC_W−1. Otherwise acc_x ← s.
- Falling edge of VISIBLE_I (vis_d=1, VISIBLE_I=0): end of line.
  - col and acc_x are cleared.
  - t = acc_y + SRC_H. If t ≥ DST_H: acc_y ← t − DST_H and, if row < SRC_H−1, row ← row+1 and row_base ← row_base + SRC_W. Otherwise acc_y ← t.
- Resulting mapping: output pixel i of line j reads source (floor(i·SRC_W/DST_W), floor(j·SRC_H/DST_H)). Extra pixels or lines beyond DST_W/DST_H clamp to the last column or row.
- No multiplier is allowed; row_base is built by accumulation.
- Colour stage registers one cycle after data is valid. While the delayed VISIBLE is 0 the output is R=G=B=0. Otherwise:
  - 00: R=G=B=DOUT.
  - 01: R=G=B=~DOUT.
  - 10: R=0, G=DOUT, B=0.
  - 11: R=G=B = all-ones if (delayed col[0] ^ row[0]) else 0. BRAM data is ignored, and the address sequence is unchanged.
- MODE is sampled at the colour stage each cycle, so a change takes effect on the next pixel.
- ENABLE=0 freezes all registers, including the delay pipelines and vis_d, and outputs hold.

## Timing
- BRAM_ADDR for a pixel is valid 1 cycle after that pixel's VISIBLE_I cycle.
- BRAM_DOUT is expected BRAM_LATENCY cycles later.
- VGA_R/G/B and the delayed HS/VS/VISIBLE appear PIPE = BRAM_LATENCY+2 cycles after the input pixel, mutually aligned.
- When VS_I=1 coincides with the falling edge of VISIBLE_I, the frame restart has priority.
- RESET_N assertion clears all state immediately, independent of CLK. After release, nothing is fetched until the next VS_I, even if a line is in progress.
- Throughput is one pixel per clock, with no stalls.

## Test plan
- Reset: RESET_N=0 with toggling timing inputs → BRAM_ADDR=0, RGB=0, delayed syncs=0. After release with VISIBLE_I=1 before any VS_I → BRAM_ADDR stays 0.
- First line at defaults: VS_I pulse, then 640 VISIBLE_I cycles → BRAM_ADDR sequence is 0×5, 1×5, …, 127×5.
- Line stepping: full 480-line frame → lines 0–4 use base 0, line 5 uses base 128, line 479 uses base 12160 (row 95). The next VS_I restarts at 0.
- Overrun: a 650-pixel line and 490 lines → columns 640–649 read col 127, and lines 480–489 read row 95. No address exceeds 12287.
- Modes at BRAM_LATENCY=2, BRAM_DOUT=0x3C: MODE 00 → 3C/3C/3C; MODE 01 → C3/C3/C3; MODE 10 → 00/3C/00. Output appears 4 cycles after VISIBLE_I, with 0 during blanking.
- Async reset at pixel 300 of line 10 → all outputs are 0 within the same cycle. Mid-frame ENABLE=0 for 7 cycles → BRAM_ADDR and outputs hold, then resume with no skipped address.

Source files
------------

// File: rtl/vga_scale_fetch.sv
// rtl/vga_scale_fetch.sv - frame-buffer fetch with DDA nearest-neighbour upscaling and colour mapping
// Maps each visible output pixel to a source pixel, issues the BRAM read,
// and realigns the returned data with the delayed raster timing.
module vga_scale_fetch #(
  parameter int SRC_W        = 128,
  parameter int SRC_H        = 96,
  parameter int DST_W        = 640,
  parameter int DST_H        = 480,
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int BRAM_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic [1:0]        MODE,
  input  logic              VGA_HS_I,
  input  logic              VGA_VS_I,
  input  logic              VGA_VISIBLE_I,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  input  logic [DATA_W-1:0] BRAM_DOUT,
  output logic [DATA_W-1:0] VGA_R,
  output logic [DATA_W-1:0] VGA_G,
  output logic [DATA_W-1:0] VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_VISIBLE
);

  // Address register is stage 1, data returns BRAM_LATENCY later, colour register is the last stage.
  localparam int PIPE = BRAM_LATENCY + 2;
  localparam int CW   = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int RW   = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int AXW  = $clog2(DST_W) + 1;
  localparam int AYW  = $clog2(DST_H) + 1;

  localparam logic [AXW-1:0]    SRC_W_X = AXW'(SRC_W);
  localparam logic [AXW-1:0]    DST_W_X = AXW'(DST_W);
  localparam logic [AYW-1:0]    SRC_H_Y = AYW'(SRC_H);
  localparam logic [AYW-1:0]    DST_H_Y = AYW'(DST_H);
  localparam logic [CW-1:0]     COL_MAX = CW'(SRC_W - 1);
  localparam logic [RW-1:0]     ROW_MAX = RW'(SRC_H - 1);
  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
  localparam logic [DATA_W-1:0] ONES    = {DATA_W{1'b1}};

  logic              armed;
  logic              vis_d;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] row_base;
  logic [AXW-1:0]    acc_x;
  logic [AYW-1:0]    acc_y;
  logic [AXW-1:0]    sum_x;
  logic [AYW-1:0]    sum_y;
  logic [PIPE-1:0]   hs_pipe;
  logic [PIPE-1:0]   vs_pipe;
  logic [PIPE-1:0]   vis_pipe;
  logic [PIPE-1:0]   chk_pipe;

  // Candidate DDA sums for one horizontal pixel step and one vertical line step.
  always_comb begin
    sum_x = acc_x + SRC_W_X;
    sum_y = acc_y + SRC_H_Y;
  end

  // Source coordinate tracking and read address generation; frame restart wins over end of line.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      armed     <= 1'b0;
      vis_d     <= 1'b0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      BRAM_ADDR <= '0;
    end else if (ENABLE) begin
      vis_d <= VGA_VISIBLE_I;
      if (VGA_VS_I) begin
        armed     <= 1'b1;
        col       <= '0;
        row       <= '0;
        row_base  <= '0;
        acc_x     <= '0;
        acc_y     <= '0;
        BRAM_ADDR <= '0;
      end else if (armed) begin
        if (VGA_VISIBLE_I) begin
          BRAM_ADDR <= row_base + ADDR_W'(col);
          if (sum_x >= DST_W_X) begin
            acc_x <= sum_x - DST_W_X;
            if (col != COL_MAX) col <= col + 1'b1;
          end else begin
            acc_x <= sum_x;
          end
        end else if (vis_d) begin
          col   <= '0;
          acc_x <= '0;
          if (sum_y >= DST_H_Y) begin
            acc_y <= sum_y - DST_H_Y;
            if (row != ROW_MAX) begin
              row      <= row + 1'b1;
              row_base <= row_base + SRC_W_A;
            end
          end else begin
            acc_y <= sum_y;
          end
        end
      end
    end
  end

  // Timing and checker-parity delay lines keep every strobe aligned with the returned pixel.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      vis_pipe <= '0;
      chk_pipe <= '0;
    end else if (ENABLE) begin
      hs_pipe  <= {hs_pipe[PIPE-2:0], VGA_HS_I};
      vs_pipe  <= {vs_pipe[PIPE-2:0], VGA_VS_I};
      vis_pipe <= {vis_pipe[PIPE-2:0], VGA_VISIBLE_I};
      chk_pipe <= {chk_pipe[PIPE-2:0], col[0] ^ row[0]};
    end
  end

  // Colour mapping registered in the cycle the BRAM data for this pixel is valid.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (ENABLE) begin
      if (!armed || !vis_pipe[PIPE-2]) begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end else begin
        case (MODE)
          2'b00: begin
            VGA_R <= BRAM_DOUT;
            VGA_G <= BRAM_DOUT;
            VGA_B <= BRAM_DOUT;
          end
          2'b01: begin
            VGA_R <= ~BRAM_DOUT;
            VGA_G <= ~BRAM_DOUT;
            VGA_B <= ~BRAM_DOUT;
          end
          2'b10: begin
            VGA_R <= '0;
            VGA_G <= BRAM_DOUT;
            VGA_B <= '0;
          end
          default: begin
            VGA_R <= chk_pipe[PIPE-2] ? ONES : '0;
            VGA_G <= chk_pipe[PIPE-2] ? ONES : '0;
            VGA_B <= chk_pipe[PIPE-2] ? ONES : '0;
          end
        endcase
      end
    end
  end

  assign VGA_HS      = hs_pipe[PIPE-1];
  assign VGA_VS      = vs_pipe[PIPE-1];
  assign VGA_VISIBLE = vis_pipe[PIPE-1];

endmodule

// File: tb/tb_vga_scale_fetch.sv
// tb/tb_vga_scale_fetch.sv - self-checking bench for vga_scale_fetch
module tb_vga_scale_fetch;

  localparam int SW   = 12;
  localparam int SH   = 9;
  localparam int DW   = 40;
  localparam int DH   = 30;
  localparam int AW   = 8;
  localparam int LAT  = 2;
  localparam int PIPE = LAT + 2;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          ENABLE = 1'b1;
  logic [1:0]    MODE = 2'b00;
  logic          VGA_HS_I = 1'b0;
  logic          VGA_VS_I = 1'b0;
  logic          VGA_VISIBLE_I = 1'b0;
  logic [AW-1:0] BRAM_ADDR;
  logic [7:0]    BRAM_DOUT = 8'h00;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, VGA_VISIBLE;

  always #5 CLK = ~CLK;

  vga_scale_fetch #(
    .SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH),
    .ADDR_W(AW), .DATA_W(8), .BRAM_LATENCY(LAT)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .MODE(MODE),
    .VGA_HS_I(VGA_HS_I), .VGA_VS_I(VGA_VS_I), .VGA_VISIBLE_I(VGA_VISIBLE_I),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DOUT(BRAM_DOUT),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_VISIBLE(VGA_VISIBLE)
  );

  int  n_chk = 0;
  int  n_fail = 0;
  bit  force_data = 1'b0;

  function automatic logic [7:0] dfun(input logic [AW-1:0] a);
    return a * 8'd29 + 8'd17;
  endfunction

  // BRAM with read latency LAT and a clock enable shared with the fetch stage
  logic [AW-1:0] bram_a1 = '0;
  always_ff @(posedge CLK) begin
    if (ENABLE) begin
      bram_a1   <= BRAM_ADDR;
      BRAM_DOUT <= force_data ? 8'h3C : dfun(bram_a1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: coordinates from pixel/line counts by integer division
  typedef struct { bit vs; bit hs; bit vis; bit chk; int addr; } rec_t;
  rec_t hist[$];
  int   m_i, m_j, e_addr;
  bit   m_armed, m_visp;
  logic [7:0] e_r, e_g, e_b;
  logic e_hs, e_vs, e_vis;

  task automatic model_reset();
    rec_t z;
    z.vs = 0; z.hs = 0; z.vis = 0; z.chk = 0; z.addr = 0;
    m_i = 0; m_j = 0; e_addr = 0; m_armed = 0; m_visp = 0;
    e_r = 0; e_g = 0; e_b = 0; e_hs = 0; e_vs = 0; e_vis = 0;
    hist.delete();
    for (int k = 0; k < PIPE - 1; k++) hist.push_back(z);
  endtask

  task automatic model_step();
    rec_t c, r;
    bit armed_before;
    int col, row;
    logic [7:0] d;
    c.vs = VGA_VS_I; c.hs = VGA_HS_I; c.vis = VGA_VISIBLE_I; c.chk = 0; c.addr = 0;
    armed_before = m_armed;
    if (VGA_VS_I) begin
      m_armed = 1; e_addr = 0; m_i = 0; m_j = 0;
    end else if (m_armed) begin
      if (VGA_VISIBLE_I) begin
        col = (m_i * SW) / DW; if (col > SW - 1) col = SW - 1;
        row = (m_j * SH) / DH; if (row > SH - 1) row = SH - 1;
        e_addr = row * SW + col;
        c.addr = e_addr;
        c.chk  = ((col + row) % 2) == 1;
        m_i++;
      end else if (m_visp) begin
        m_i = 0; m_j++;
      end
    end
    m_visp = VGA_VISIBLE_I;
    hist.push_back(c);
    r = hist.pop_front();
    e_hs = r.hs; e_vs = r.vs; e_vis = r.vis;
    d = force_data ? 8'h3C : dfun(AW'(r.addr));
    if (r.vis && armed_before) begin
      case (MODE)
        2'd0: begin e_r = d;  e_g = d;  e_b = d;  end
        2'd1: begin e_r = ~d; e_g = ~d; e_b = ~d; end
        2'd2: begin e_r = 0;  e_g = d;  e_b = 0;  end
        default: begin
          e_r = r.chk ? 8'hFF : 8'h00; e_g = e_r; e_b = e_r;
        end
      endcase
    end else begin
      e_r = 0; e_g = 0; e_b = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) model_reset();
      else if (ENABLE) model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge CLK);
      chk("addr", 32'(BRAM_ADDR), 32'(e_addr));
      chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'({e_r, e_g, e_b}));
      chk("sync", 32'({VGA_HS, VGA_VS, VGA_VISIBLE}), 32'({e_hs, e_vs, e_vis}));
    end
  end

  typedef struct { int line; int pix; int addr; } probe_t;
  probe_t probes[$];
  int cur_line = 0;
  int stall_line = -1;
  int stall_pix = -1;
  int stall_addr = 0;
  bit mode_walk = 0;

  task automatic add_probe(input int l, input int p, input int a);
    probe_t pr;
    pr.line = l; pr.pix = p; pr.addr = a;
    probes.push_back(pr);
  endtask

  task automatic tick(input logic vs, input logic hs, input logic vis);
    @(negedge CLK);
    VGA_VS_I = vs; VGA_HS_I = hs; VGA_VISIBLE_I = vis; ENABLE = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic hold();
    @(negedge CLK);
    ENABLE = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic blank(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, (k >= 2 && k < 5), 1'b0);
  endtask

  task automatic vs_pulse();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    blank(4);
    cur_line = 0;
  endtask

  task automatic run_line(input int np, input int stop, input bit do_blank);
    for (int p = 0; p < np; p++) begin
      if (mode_walk) MODE = 2'((cur_line + ((p >= 20) ? 1 : 0)) % 4);
      tick(1'b0, 1'b0, 1'b1);
      foreach (probes[k]) begin
        if (probes[k].line == cur_line && probes[k].pix == p) begin
          chk("probe_addr", 32'(BRAM_ADDR), 32'(probes[k].addr));
          chk("probe_model", 32'(e_addr), 32'(probes[k].addr));
        end
      end
      if (cur_line == stall_line && p == stall_pix) begin
        for (int k = 0; k < 7; k++) begin
          hold();
          chk("stall_addr", 32'(BRAM_ADDR), 32'(stall_addr));
        end
      end
      if (p == stop) return;
    end
    if (do_blank) blank(8);
    cur_line++;
  endtask

  task automatic run_frame(input int nl, input int np, input bit last_blank);
    vs_pulse();
    for (int l = 0; l < nl; l++) run_line(np, -1, (l < nl - 1) || last_blank);
  endtask

  task automatic mode_check(input logic [1:0] m, input logic [23:0] exp_rgb);
    MODE = m;
    vs_pulse();
    force_data = 1'b1;
    blank(4);
    for (int p = 0; p < 40; p++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (p == 2) begin
        chk("mode_pre_vis", 32'(VGA_VISIBLE), 32'(0));
        chk("mode_pre_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
      end
      if (p == 3) chk("mode_lat_vis", 32'(VGA_VISIBLE), 32'(1));
      if (p == 13) chk("mode_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
    end
    blank(8);
    chk("mode_blank_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
  endtask

  initial begin
    // reset with toggling timing inputs
    for (int k = 0; k < 6; k++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("rst_addr", 32'(BRAM_ADDR), 32'(0));
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
    chk("rst_sync", 32'({VGA_HS, VGA_VS, VGA_VISIBLE}), 32'(0));
    tick(1'b0, 1'b0, 1'b0);
    @(negedge CLK); RESET_N = 1'b1;

    // visible line before any VS: nothing fetched
    for (int p = 0; p < 40; p++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (p == 0 || p == 39) chk("unarmed_addr", 32'(BRAM_ADDR), 32'(0));
      if (p == 39) chk("unarmed_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
    end
    blank(8);

    // full frame, mode changes every line and mid-line, ENABLE stall mid-frame
    add_probe(0, 0, 0);   add_probe(0, 3, 0);   add_probe(0, 4, 1);
    add_probe(0, 39, 11); add_probe(3, 5, 1);   add_probe(4, 0, 12);
    add_probe(6, 17, 17); add_probe(6, 20, 18); add_probe(10, 14, 40);
    add_probe(29, 39, 107);
    mode_walk = 1; stall_line = 6; stall_pix = 17; stall_addr = 17;
    run_frame(30, 40, 1'b1);
    stall_line = -1;

    // overrun frame; the last line falls straight into the next VS
    probes.delete();
    add_probe(0, 40, 11); add_probe(0, 44, 11); add_probe(9, 0, 24);
    add_probe(30, 0, 96); add_probe(33, 44, 107);
    run_frame(34, 45, 1'b0);
    mode_walk = 0;

    // colour modes on constant data
    probes.delete();
    mode_check(2'd0, 24'h3C3C3C);
    mode_check(2'd1, 24'hC3C3C3);
    mode_check(2'd2, 24'h003C00);
    mode_check(2'd3, 24'hFFFFFF);
    force_data = 1'b0;
    MODE = 2'd0;

    // asynchronous reset in the middle of line 10
    vs_pulse();
    for (int l = 0; l < 10; l++) run_line(40, -1, 1'b1);
    run_line(40, 20, 1'b1);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_addr", 32'(BRAM_ADDR), 32'(0));
    chk("async_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
    chk("async_sync", 32'({VGA_HS, VGA_VS, VGA_VISIBLE}), 32'(0));
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge CLK); RESET_N = 1'b1;
    for (int p = 23; p < 40; p++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (p == 39) chk("post_rst_addr", 32'(BRAM_ADDR), 32'(0));
    end
    blank(8);
    add_probe(0, 4, 1); add_probe(2, 39, 11);
    run_frame(3, 40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
